// File: rtl/fpga_cap_pkg.sv
// Shared types and constants for the FIR snapshot capture buffer.
// State encoding, register map indices, trigger modes, CTRL bit positions.
package fpga_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CFG    = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  localparam logic [1:0] MODE_IMM   = 2'd0;
  localparam logic [1:0] MODE_LEVEL = 2'd1;
  localparam logic [1:0] MODE_FRAME = 2'd2;

  localparam int CTRL_ARM     = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_MODE_LO = 2;
  localparam int STAT_IRQ     = 2;

  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/fpga_capture_buf_if.sv
// Bus bundle for the capture buffer: AXI4-Stream sample sink, APB slave, irq.
// slave = capture buffer side, master = filter/CPU side.
interface fpga_capture_buf_if;
  logic [7:0]  axis4_s_tdata;
  logic        axis4_s_tvalid;
  logic        axis4_s_tready;
  logic        axis4_s_tlast;
  logic [3:0]  apb_slave_paddr;
  logic        apb_slave_psel;
  logic        apb_slave_penable;
  logic        apb_slave_pwrite;
  logic [31:0] apb_slave_pwdata;
  logic [31:0] apb_slave_prdata;
  logic        apb_slave_pready;
  logic        irq;

  modport slave (
    input  axis4_s_tdata, axis4_s_tvalid, axis4_s_tlast,
    output axis4_s_tready,
    input  apb_slave_paddr, apb_slave_psel, apb_slave_penable,
    input  apb_slave_pwrite, apb_slave_pwdata,
    output apb_slave_prdata, apb_slave_pready,
    output irq
  );

  modport master (
    output axis4_s_tdata, axis4_s_tvalid, axis4_s_tlast,
    input  axis4_s_tready,
    output apb_slave_paddr, apb_slave_psel, apb_slave_penable,
    output apb_slave_pwrite, apb_slave_pwdata,
    input  apb_slave_prdata, apb_slave_pready,
    input  irq
  );
endinterface

// File: rtl/fpga_cap_ram.sv
// Simple dual-port 32-bit sample RAM with byte enables and registered read.
// Ports: clk, write port (we/waddr/be/wdata), read port (re/raddr/rdata).
module fpga_cap_ram #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fpga_capture_buf.sv
// Snapshot capture of filtered AXIS samples, read back over APB as packed words.
// Ports: clk, rstn (async low), bus (AXIS sink + APB slave + irq).
module fpga_capture_buf
  import fpga_cap_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input logic clk,
  input logic rstn,
  fpga_capture_buf_if.slave bus
);

  localparam int AW = DEPTH_LOG2 - 2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  cap_state_e         state;
  logic               irq_q;
  logic [CW-1:0]      count;
  logic [AW-1:0]      rd_widx;
  logic [1:0]         mode;
  logic signed [7:0]  thr;
  logic [15:0]        len;
  logic signed [7:0]  prev;
  logic               prev_valid;
  logic               last_seen;
  logic               rd_wait;

  logic               acc, wr, rd;
  logic [1:0]         ridx;
  logic               data_rd, ctrl_wr;
  logic               arm, abort;
  logic               beat, trig;
  logic signed [7:0]  sample;
  logic [CW-1:0]      len_eff;
  logic [CW-1:0]      count_nx;

  logic               ram_we, ram_re;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [31:0]        ram_q;
  logic [31:0]        data_word;
  logic [31:0]        rdata;
  logic               unused_ok;

  assign acc     = bus.apb_slave_psel & bus.apb_slave_penable;
  assign wr      = acc & bus.apb_slave_pwrite;
  assign rd      = acc & ~bus.apb_slave_pwrite;
  assign ridx    = bus.apb_slave_paddr[3:2];
  assign data_rd = rd & (ridx == REG_DATA);
  assign ctrl_wr = wr & (ridx == REG_CTRL);
  assign arm     = ctrl_wr & bus.apb_slave_pwdata[CTRL_ARM];
  assign abort   = ctrl_wr & bus.apb_slave_pwdata[CTRL_ABORT];
  assign beat    = bus.axis4_s_tvalid;
  assign sample  = bus.axis4_s_tdata;
  assign count_nx = count + 1'b1;

  assign unused_ok = ^{bus.apb_slave_pwdata[15:8],
                       bus.apb_slave_paddr[1:0]};

  // LEN of 0 or beyond the RAM means a full-depth capture.
  always_comb begin
    len_eff = len[CW-1:0];
    if (len == 16'd0 || len > 16'(DEPTH)) len_eff = DEPTH;
  end

  always_comb begin
    trig = 1'b1;
    unique case (1'b1)
      (mode == MODE_LEVEL):
        trig = prev_valid && (prev < thr) && (sample >= thr);
      (mode == MODE_FRAME):
        trig = last_seen;
      default:
        trig = 1'b1;
    endcase
  end

  // A beat in the same cycle as ARM/ABORT is dropped.
  assign ram_we = beat & ~arm & ~abort &
                  (((state == ARMED) & trig) | (state == CAPTURE));
  assign wr_idx = (state == ARMED) ? '0 : count[DEPTH_LOG2-1:0];
  assign ram_re = data_rd & ~rd_wait;

  fpga_cap_ram #(.ADDR_W(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_idx[DEPTH_LOG2-1:2]),
    .be    (lane_be(wr_idx[1:0])),
    .wdata ({4{bus.axis4_s_tdata}}),
    .re    (ram_re),
    .raddr (rd_widx),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      irq_q      <= 1'b0;
      count      <= '0;
      rd_widx    <= '0;
      mode       <= MODE_IMM;
      thr        <= '0;
      len        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      last_seen  <= 1'b0;
      rd_wait    <= 1'b0;
    end else begin
      rd_wait <= data_rd & ~rd_wait;
      if (data_rd && rd_wait && state == DONE) rd_widx <= rd_widx + 1'b1;
      if (ctrl_wr) mode <= bus.apb_slave_pwdata[CTRL_MODE_LO +: 2];
      if (wr && ridx == REG_CFG) begin
        thr <= bus.apb_slave_pwdata[7:0];
        len <= bus.apb_slave_pwdata[31:16];
      end
      if (abort) begin
        state <= IDLE;
        irq_q <= 1'b0;
      end else if (arm) begin
        state      <= ARMED;
        count      <= '0;
        rd_widx    <= '0;
        irq_q      <= 1'b0;
        prev_valid <= 1'b0;
        last_seen  <= 1'b0;
      end else begin
        if (wr && ridx == REG_STATUS && bus.apb_slave_pwdata[STAT_IRQ])
          irq_q <= 1'b0;
        if (beat) begin
          case (state)
            ARMED: begin
              prev       <= sample;
              prev_valid <= 1'b1;
              last_seen  <= bus.axis4_s_tlast;
              if (trig) begin
                count <= CW'(1);
                if (len_eff == CW'(1)) begin
                  state <= DONE;
                  irq_q <= 1'b1;
                end else begin
                  state <= CAPTURE;
                end
              end
            end
            CAPTURE: begin
              count <= count_nx;
              if (count_nx == len_eff) begin
                state <= DONE;
                irq_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Bytes past the captured length are zeroed so stale RAM never leaks.
  always_comb begin
    data_word = '0;
    for (int b = 0; b < 4; b++) begin
      if ({1'b0, rd_widx, 2'(b)} < count)
        data_word[8*b +: 8] = ram_q[8*b +: 8];
    end
  end

  assign bus.apb_slave_pready = ~(data_rd & ~rd_wait);

  always_comb begin
    rdata = '1;
    if (rd && bus.apb_slave_pready) begin
      case (ridx)
        REG_CTRL:   rdata = {28'd0, mode, 2'b00};
        REG_STATUS: rdata = {16'(count), 13'd0, irq_q, state};
        REG_CFG:    rdata = {len, 8'd0, thr};
        default:    rdata = (state == DONE) ? data_word : 32'd0;
      endcase
    end
  end

  assign bus.apb_slave_prdata = rdata;
  assign bus.axis4_s_tready   = 1'b1;
  assign bus.irq              = irq_q;

endmodule
